// File: rtl/condicionador_sensores_if.sv
`default_nettype none
// ============================================================================
// condicionador_sensores_if : switch-conditioning signal bundle
// Revision: 1.0
// ============================================================================
interface condicionador_sensores_if;
  logic [3:0] s_bruto;
  logic       limpar;
  logic [3:0] s_filtrado;
  logic       erro_inf;
  logic       erro_sup;
  logic       falha_inf;
  logic       falha_sup;
  logic       pronto;

  modport master (
    output s_bruto, limpar,
    input  s_filtrado, erro_inf, erro_sup, falha_inf, falha_sup, pronto
  );

  modport slave (
    input  s_bruto, limpar,
    output s_filtrado, erro_inf, erro_sup, falha_inf, falha_sup, pronto
  );
endinterface
`default_nettype wire

// File: rtl/condicionador_sensores.sv
`default_nettype none
// ============================================================================
// condicionador_sensores : sync + debounce of four float switches, plausibility
// flags and sticky per-tank faults for the pump controller.
// Revision: 1.0
// ============================================================================
module condicionador_sensores #(
  parameter int N_DEB   = 8,
  parameter int N_FALHA = 16
) (
  input  logic clk,
  input  logic rst,
  condicionador_sensores_if.slave bus
);
  localparam logic [7:0] DEB_LAST   = 8'(N_DEB - 1);
  localparam logic [7:0] FALHA_MAX  = 8'(N_FALHA);
  localparam logic [7:0] START_LAST = 8'(N_DEB);

  logic [3:0]      sync1_q, sync2_q;
  logic [3:0]      filt_q, filt_d;
  logic [3:0][7:0] cnt_q, cnt_d;
  logic            erro_inf_q, erro_inf_d, erro_sup_q, erro_sup_d;
  logic [7:0]      fc_inf_q, fc_inf_d, fc_sup_q, fc_sup_d;
  logic            falha_inf_q, falha_inf_d, falha_sup_q, falha_sup_d;
  logic [7:0]      start_q, start_d;
  logic            armed_q, armed_d, pronto_q, pronto_d;

  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DEB_LAST) begin
        filt_d[i] = sync2_q[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end

    erro_inf_d = ~filt_q[0] & filt_q[1];
    erro_sup_d = ~filt_q[2] & filt_q[3];

    // Fault counters saturate so a persisting error keeps re-asserting the set,
    // which is what lets set take priority over limpar.
    fc_inf_d = '0;
    if (erro_inf_q) fc_inf_d = (fc_inf_q == FALHA_MAX) ? fc_inf_q : fc_inf_q + 8'd1;
    fc_sup_d = '0;
    if (erro_sup_q) fc_sup_d = (fc_sup_q == FALHA_MAX) ? fc_sup_q : fc_sup_q + 8'd1;

    falha_inf_d = (erro_inf_q && fc_inf_d == FALHA_MAX) || (falha_inf_q && !bus.limpar);
    falha_sup_d = (erro_sup_q && fc_sup_d == FALHA_MAX) || (falha_sup_q && !bus.limpar);

    // armed adds one stage so pronto lands on edge N_DEB+2 without a 9-bit counter.
    start_d  = (start_q == START_LAST) ? start_q : start_q + 8'd1;
    armed_d  = armed_q | (start_q == START_LAST);
    pronto_d = pronto_q | armed_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      filt_q      <= '0;
      cnt_q       <= '0;
      erro_inf_q  <= 1'b0;
      erro_sup_q  <= 1'b0;
      fc_inf_q    <= '0;
      fc_sup_q    <= '0;
      falha_inf_q <= 1'b0;
      falha_sup_q <= 1'b0;
      start_q     <= '0;
      armed_q     <= 1'b0;
      pronto_q    <= 1'b0;
    end else begin
      sync1_q     <= bus.s_bruto;
      sync2_q     <= sync1_q;
      filt_q      <= filt_d;
      cnt_q       <= cnt_d;
      erro_inf_q  <= erro_inf_d;
      erro_sup_q  <= erro_sup_d;
      fc_inf_q    <= fc_inf_d;
      fc_sup_q    <= fc_sup_d;
      falha_inf_q <= falha_inf_d;
      falha_sup_q <= falha_sup_d;
      start_q     <= start_d;
      armed_q     <= armed_d;
      pronto_q    <= pronto_d;
    end
  end

  assign bus.s_filtrado = filt_q;
  assign bus.erro_inf   = erro_inf_q;
  assign bus.erro_sup   = erro_sup_q;
  assign bus.falha_inf  = falha_inf_q;
  assign bus.falha_sup  = falha_sup_q;
  assign bus.pronto     = pronto_q;
endmodule
`default_nettype wire

// File: tb/tb_condicionador_sensores.sv
`default_nettype none
// ============================================================================
// tb_condicionador_sensores : directed sequences, vector table and random
// stimulus against a window-based reference model.
// Revision: 1.0
// ============================================================================
module tb_condicionador_sensores;
  localparam int N_DEB   = 8;
  localparam int N_FALHA = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  condicionador_sensores_if bus ();

  condicionador_sensores #(.N_DEB(N_DEB), .N_FALHA(N_FALHA)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an output bit flips once the last N_DEB synchronised
  // samples all disagree with it; faults track an unbounded persistence count.
  logic [3:0] m_s1, m_s2, m_filt;
  logic       m_ei, m_es, m_fi, m_fs, m_pronto;
  int         m_pi, m_ps, m_edges;
  logic [3:0] hist[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_filt = '0;
      m_ei = 0; m_es = 0; m_fi = 0; m_fs = 0; m_pronto = 0;
      m_pi = 0; m_ps = 0; m_edges = 0;
      hist.delete();
    end else begin
      logic [3:0] nf;
      nf = m_filt;
      hist.push_back(m_s2);
      if (hist.size() > N_DEB) void'(hist.pop_front());
      for (int i = 0; i < 4; i++) begin
        bit all_diff;
        all_diff = (hist.size() == N_DEB);
        foreach (hist[k]) if (hist[k][i] == m_filt[i]) all_diff = 0;
        if (all_diff) nf[i] = ~m_filt[i];
      end
      m_pi = m_ei ? m_pi + 1 : 0;
      m_ps = m_es ? m_ps + 1 : 0;
      m_fi = (m_pi >= N_FALHA) ? 1'b1 : (bus.limpar ? 1'b0 : m_fi);
      m_fs = (m_ps >= N_FALHA) ? 1'b1 : (bus.limpar ? 1'b0 : m_fs);
      m_ei = (m_filt[1:0] == 2'b10);
      m_es = (m_filt[3:2] == 2'b10);
      m_filt = nf;
      m_edges++;
      m_pronto = (m_edges >= N_DEB + 2);
      m_s2 = m_s1;
      m_s1 = bus.s_bruto;
    end
  end

  always @(negedge clk) begin
    check("model", {23'd0, bus.s_filtrado, bus.erro_inf, bus.erro_sup,
                    bus.falha_inf, bus.falha_sup, bus.pronto},
                   {23'd0, m_filt, m_ei, m_es, m_fi, m_fs, m_pronto});
  end

  typedef struct {
    logic [3:0] sb;
    logic       lim;
    int         hold;
    logic [3:0] f;
    logic       ei, es, fi, fs;
  } vec_t;

  vec_t tbl[7];

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    tbl[0] = '{4'b0000, 1'b0, 12, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{4'b0010, 1'b0, 12, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{4'b0010, 1'b0, 20, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{4'b1011, 1'b0, 12, 4'b1011, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{4'b1011, 1'b1, 30, 4'b1011, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{4'b1111, 1'b1, 13, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{4'b0101, 1'b0, 12, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0};

    bus.s_bruto = 4'b0011;
    bus.limpar  = 1'b0;

    // Reset and startup
    #1;
    check("rst_outputs", {bus.s_filtrado, bus.erro_inf, bus.erro_sup,
                          bus.falha_inf, bus.falha_sup, bus.pronto}, 0);
    ticks(3);
    check("rst_hold", {bus.s_filtrado, bus.pronto}, 0);
    rst = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      check("start_pronto", bus.pronto, (j == 10));
      check("start_filt", bus.s_filtrado, (j == 10) ? 4'b0011 : 4'b0000);
    end

    // Glitch rejection then a clean pulse
    bus.s_bruto = 4'b0000;
    ticks(12);
    check("settle0", bus.s_filtrado, 4'b0000);
    bus.s_bruto = 4'b0001;
    ticks(5);
    bus.s_bruto = 4'b0000;
    ticks(12);
    check("glitch5", bus.s_filtrado, 4'b0000);
    bus.s_bruto = 4'b0001;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      check("pulse_lat", bus.s_filtrado[0], (j == 10));
    end
    ticks(2);
    bus.s_bruto = 4'b0000;
    ticks(12);
    check("pulse_fall", bus.s_filtrado, 4'b0000);

    // Asynchronous reset mid-debounce
    bus.s_bruto = 4'b0001;
    ticks(12);
    check("pre_rst", bus.s_filtrado, 4'b0001);
    bus.s_bruto = 4'b0101;
    ticks(6);
    #2 rst = 1'b1;
    #1;
    check("async_filt", bus.s_filtrado, 4'b0000);
    check("async_pronto", bus.pronto, 0);
    ticks(2);
    rst = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      check("rerun_filt", bus.s_filtrado, (j == 10) ? 4'b0101 : 4'b0000);
      check("rerun_pronto", bus.pronto, (j == 10));
    end

    // Impossible lower-tank combination
    bus.s_bruto = 4'b0010;
    for (int j = 1; j <= 27; j++) begin
      @(negedge clk);
      if (j == 10) check("imp_filt", bus.s_filtrado, 4'b0010);
      if (j == 10 || j == 11) check("imp_erro", bus.erro_inf, (j == 11));
      if (j == 26 || j == 27) check("imp_falha", bus.falha_inf, (j == 27));
    end
    check("imp_sup", {bus.erro_sup, bus.falha_sup}, 0);
    bus.s_bruto = 4'b0000;
    ticks(11);
    check("imp_clear_erro", bus.erro_inf, 0);
    check("imp_sticky", bus.falha_inf, 1);

    // limpar priority
    bus.s_bruto = 4'b1000;
    ticks(30);
    check("sup_falha", {bus.erro_sup, bus.falha_sup}, 2'b11);
    bus.limpar = 1'b1;
    @(negedge clk);
    bus.limpar = 1'b0;
    check("lim_set_wins", bus.falha_sup, 1);
    check("lim_clears_inf", bus.falha_inf, 0);
    bus.s_bruto = 4'b1100;
    ticks(15);
    check("legal_sup", {bus.erro_sup, bus.falha_sup}, 2'b01);
    bus.limpar = 1'b1;
    @(negedge clk);
    bus.limpar = 1'b0;
    check("lim_clear_sup", bus.falha_sup, 0);

    // Simultaneous channels
    bus.s_bruto = 4'b0000;
    ticks(12);
    bus.s_bruto = 4'b1111;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      check("simul_filt", bus.s_filtrado, (j >= 10) ? 4'b1111 : 4'b0000);
      check("simul_erro", {bus.erro_inf, bus.erro_sup}, 0);
    end

    // Vector table
    for (int r = 0; r < 7; r++) begin
      bus.s_bruto = tbl[r].sb;
      bus.limpar  = tbl[r].lim;
      ticks(tbl[r].hold);
      bus.limpar  = 1'b0;
      check($sformatf("tbl%0d", r),
            {bus.s_filtrado, bus.erro_inf, bus.erro_sup, bus.falha_inf, bus.falha_sup},
            {tbl[r].f, tbl[r].ei, tbl[r].es, tbl[r].fi, tbl[r].fs});
    end

    // Random stimulus, checked by the model every cycle
    for (int n = 0; n < 60; n++) begin
      int hold;
      bus.s_bruto = 4'($urandom);
      hold = $urandom_range(1, 40);
      for (int c = 0; c < hold; c++) begin
        bus.limpar = ($urandom_range(0, 15) == 0);
        @(negedge clk);
      end
      if ($urandom_range(0, 19) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end
    bus.limpar = 1'b0;
    ticks(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/condicionador_sensores.md
Name: condicionador_sensores

Overview:
Input-conditioning stage directly upstream of the pump controller (controlador_bombas).
- Takes the four raw float-switch signals (s1/s2 for the lower tank, s3/s4 for the upper tank) and synchronises and debounces each one.
- Drives the clean levels into the controller's s1..s4 inputs.
- Flags and latches physically impossible switch combinations (upper switch wet, lower switch dry) per tank, so they are caught before the pump FSMs act on them.

Parameters:
N_DEB, 8, consecutive cycles a synchronised input must differ from its filtered output before the output follows (legal range 1..255).
N_FALHA, 16, consecutive cycles an impossible combination must persist before the sticky fault sets (legal range 1..255).

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
s_bruto  input  4  raw switches; bit0=s1, bit1=s2, bit2=s3, bit3=s4; asynchronous to clk.
limpar  input  1  synchronous clear of both sticky faults.
s_filtrado  output  4  debounced switches, same bit order; connects to controller s1..s4.
erro_inf  output  1  registered: s_filtrado[0]==0 & s_filtrado[1]==1.
erro_sup  output  1  registered: s_filtrado[2]==0 & s_filtrado[3]==1.
falha_inf  output  1  sticky lower-tank fault.
falha_sup  output  1  sticky upper-tank fault.
pronto  output  1  high once filtered outputs are meaningful after reset.

Behaviour:
Reset
- The block has exactly one clock (clk) and one reset (rst). rst is asynchronous and active-high.
- While rst is high, immediately and regardless of clk, all of the following clear to 0: sync flops, debounce counters, s_filtrado, erro_*, fault counters, falha_*, pronto, and the startup counter.
- Reset asserted mid-debounce discards the partial count.

Synchroniser
- Each s_bruto bit passes through 2 flops (sync1 -> sync2).
- Only sync2 is used downstream.

Debounce (per channel i, 8-bit counter cnt_i)
- If sync2_i == s_filtrado[i]: cnt_i <= 0.
- Else if cnt_i == N_DEB-1: s_filtrado[i] <= sync2_i and cnt_i <= 0.
- Else: cnt_i <= cnt_i + 1.
- Latency: a clean step on s_bruto first sampled at edge k appears on s_filtrado after edge k+N_DEB+1 (N_DEB+2 edges total).
- Any glitch shorter than N_DEB cycles at sync2 restarts the count and never reaches the output.
- Channels are fully independent. Simultaneous changes on several bits each follow their own counter.

Plausibility check
- erro_inf and erro_sup are registered from the current s_filtrado, so they lag s_filtrado by 1 cycle.
- Combinations 00, 10 and 11 per tank are legal. 01 (low switch dry, high switch wet) is an error.

Sticky fault (per tank, 8-bit counter fc)
- While the erro bit is high: fc increments, saturating at N_FALHA.
- When fc reaches N_FALHA: falha sets on the same edge and stays set.
- When the erro bit is low: fc <= 0.
- falha clears only on rst, or on a clk edge with limpar=1.
- limpar and the set condition on the same edge: set wins (falha stays 1) and fc keeps saturating.
- limpar has no effect on s_filtrado, erro_* or pronto.

Startup (pronto)
- The startup counter counts clk edges after rst deasserts.
- pronto goes high on edge N_DEB+2 after rst release and stays high until the next rst.
- s_filtrado is valid (0 or not) but is only guaranteed to reflect stable inputs once pronto=1.

Width rules
- All counters are 8 bits. Parameters outside 1..255 are illegal and are not checked in RTL.

Test Plan:
1. Reset and startup (N_DEB=8): hold rst 3 cycles with s_bruto=4'b0011, then release -> all outputs 0 during reset; pronto=1 and s_filtrado=4'b0011 on edge 10 after release.
2. Glitch rejection: from stable s_filtrado=4'b0000, pulse s_bruto[0] high for 5 cycles, then back to 0 -> s_filtrado stays 4'b0000 and cnt_0 returns to 0. A following 12-cycle pulse -> s_filtrado[0]=1 exactly N_DEB+2=10 edges after the first sampling edge.
3. Async reset mid-debounce: change s_bruto[2] to 1, then assert rst between edges at count 4 -> s_filtrado[2] and pronto drop immediately (before the next clk edge). After release, the full 10-edge latency applies again.
4. Impossible combination (N_FALHA=16): drive s_bruto=4'b0010 steadily -> erro_inf=1 one cycle after s_filtrado=4'b0010; falha_inf=1 16 cycles later; erro_sup and falha_sup stay 0. Return s_bruto to 4'b0000 -> erro_inf clears, falha_inf stays 1.
5. limpar priority: with s_bruto=4'b1000 held and falha_sup=1, pulse limpar for 1 cycle -> falha_sup stays 1 (set wins because fc is saturated). Make the condition legal (s_bruto=4'b1100), let filtering settle, then pulse limpar -> falha_sup=0 on that edge.
6. Simultaneous channels: step s_bruto from 4'b0000 to 4'b1111 in one cycle -> all four s_filtrado bits rise on the same edge. erro_inf and erro_sup never assert.
